// File: rtl/pcs_rx_descrambler_sm.sv
// pcs_rx_descrambler_sm: 1000BASE-T PCS receive side. Acquires and locks the 33-bit
// descrambler from the idle stream, tracks SSD/ESD framing and drives GMII-style rx outputs.
// Optional idle mismatch counter (with forced unlock at ERR_THRESH) is built in when
// RX_IDLE_ERR_CNT_EN is defined; ERR_THRESH exists only in that build.
module pcs_rx_descrambler_sm #(
    parameter int unsigned MASTER       = 0,
    parameter int unsigned LOCK_MATCHES = 16
`ifdef RX_IDLE_ERR_CNT_EN
    ,
    parameter int unsigned ERR_THRESH   = 8
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       io_pcs_reset,
    input  logic       io_loc_rcvr_status,
    input  logic       io_rx_symb_vector_valid,
    output logic       io_rx_symb_vector_ready,
    input  logic [2:0] io_rx_symb_vector_bits_0,
    input  logic [2:0] io_rx_symb_vector_bits_1,
    input  logic [2:0] io_rx_symb_vector_bits_2,
    input  logic [2:0] io_rx_symb_vector_bits_3,
    input  logic [7:0] io_decoded_rx_symb_vector,
    output logic [7:0] io_rxd,
    output logic       io_rx_dv,
    output logic       io_rx_er,
    output logic       io_rxerror_status,
    output logic       io_descr_lock,
    output logic [7:0] io_idle_err_cnt
);

    localparam int unsigned SCR_W    = 33;
    localparam int unsigned SYNC_LEN = 33;
    localparam int unsigned SYNC_W   = 6;
    localparam int unsigned MATCH_W  = 8;
    localparam int unsigned TAP      = (MASTER != 0) ? 12 : 19;
    localparam logic [2:0]  SYM_POS2 = 3'b010;
    localparam logic [2:0]  SYM_NEG2 = 3'b110;
    localparam logic [7:0]  FC_CODE  = 8'h0E;

    typedef enum logic [2:0] {
        ST_UNLOCKED, ST_VERIFY, ST_IDLE, ST_SSD1,
        ST_FALSE_CARRIER, ST_RECEIVE, ST_ESD1, ST_ESD_ERR
    } state_e;

    state_e               state_q, state_d;
    logic [SCR_W-1:0]     scr_q, scr_d, scr_nxt;
    logic [SYNC_W-1:0]    sync_cnt_q, sync_cnt_d;
    logic [MATCH_W-1:0]   match_cnt_q, match_cnt_d;
    logic [7:0]           rxd_q, rxd_d;
    logic                 rx_dv_q, rx_dv_d, rx_er_q, rx_er_d;
    logic                 rxerr_st_q, rxerr_st_d, lock_q, lock_d;
    logic                 accept, is_p4, is_p3n, is_data, pred_ok;
`ifdef RX_IDLE_ERR_CNT_EN
    logic [7:0]           err_cnt_q, err_cnt_d;
`endif

    // Beats are refused while either reset is asserted, so a beat never races a clear.
    assign io_rx_symb_vector_ready = reset & ~io_pcs_reset;
    assign accept  = io_rx_symb_vector_valid & io_rx_symb_vector_ready;
    assign is_p4   = (io_rx_symb_vector_bits_0 == SYM_POS2) && (io_rx_symb_vector_bits_1 == SYM_POS2)
                  && (io_rx_symb_vector_bits_2 == SYM_POS2) && (io_rx_symb_vector_bits_3 == SYM_POS2);
    assign is_p3n  = (io_rx_symb_vector_bits_0 == SYM_POS2) && (io_rx_symb_vector_bits_1 == SYM_POS2)
                  && (io_rx_symb_vector_bits_2 == SYM_POS2) && (io_rx_symb_vector_bits_3 == SYM_NEG2);
    assign is_data = ~is_p4 & ~is_p3n;
    // Free-running descrambler step; Scn for this beat is the low byte of the advanced state.
    assign scr_nxt = {scr_q[SCR_W-2:0], scr_q[TAP] ^ scr_q[SCR_W-1]};
    assign pred_ok = (io_decoded_rx_symb_vector[0] == scr_nxt[0]);

    // State, descrambler and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_UNLOCKED;
            scr_q       <= '0;
            sync_cnt_q  <= '0;
            match_cnt_q <= '0;
            rxd_q       <= '0;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            rxerr_st_q  <= 1'b0;
            lock_q      <= 1'b0;
`ifdef RX_IDLE_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else if (io_pcs_reset) begin
            state_q     <= ST_UNLOCKED;
            scr_q       <= '0;
            sync_cnt_q  <= '0;
            match_cnt_q <= '0;
            rxd_q       <= '0;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            rxerr_st_q  <= 1'b0;
            lock_q      <= 1'b0;
`ifdef RX_IDLE_ERR_CNT_EN
            err_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            scr_q       <= scr_d;
            sync_cnt_q  <= sync_cnt_d;
            match_cnt_q <= match_cnt_d;
            rxd_q       <= rxd_d;
            rx_dv_q     <= rx_dv_d;
            rx_er_q     <= rx_er_d;
            rxerr_st_q  <= rxerr_st_d;
            lock_q      <= lock_d;
`ifdef RX_IDLE_ERR_CNT_EN
            err_cnt_q   <= err_cnt_d;
`endif
        end
    end

    // Next state: lock acquisition, framing transitions and descrambler update.
    always_comb begin
        state_d     = state_q;
        scr_d       = scr_q;
        sync_cnt_d  = sync_cnt_q;
        match_cnt_d = match_cnt_q;
`ifdef RX_IDLE_ERR_CNT_EN
        err_cnt_d   = err_cnt_q;
`endif
        if (!io_loc_rcvr_status) begin
            // Receiver lost: drop to acquisition but keep Scr so relock can reuse it.
            state_d     = ST_UNLOCKED;
            sync_cnt_d  = '0;
            match_cnt_d = '0;
`ifdef RX_IDLE_ERR_CNT_EN
            err_cnt_d   = '0;
`endif
        end else if (accept) begin
            scr_d = (state_q == ST_UNLOCKED) ? {scr_q[SCR_W-2:0], io_decoded_rx_symb_vector[0]} : scr_nxt;
            case (state_q)
                ST_UNLOCKED: begin
                    if (sync_cnt_q == SYNC_W'(SYNC_LEN - 1)) begin
                        state_d    = ST_VERIFY;
                        sync_cnt_d = '0;
                    end else begin
                        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (is_data && pred_ok) begin
                        if (match_cnt_q == MATCH_W'(LOCK_MATCHES - 1)) begin
                            state_d     = ST_IDLE;
                            match_cnt_d = '0;
`ifdef RX_IDLE_ERR_CNT_EN
                            err_cnt_d   = '0;
`endif
                        end else begin
                            match_cnt_d = match_cnt_q + MATCH_W'(1);
                        end
                    end else begin
                        state_d     = ST_UNLOCKED;
                        sync_cnt_d  = '0;
                        match_cnt_d = '0;
                    end
                end
                ST_IDLE: begin
                    if (is_p4) begin
                        state_d = ST_SSD1;
                    end
`ifdef RX_IDLE_ERR_CNT_EN
                    else if (is_data && !pred_ok) begin
                        if (32'(err_cnt_q) + 32'd1 >= ERR_THRESH) begin
                            state_d   = ST_UNLOCKED;
                            err_cnt_d = '0;
                        end else if (err_cnt_q != 8'hFF) begin
                            err_cnt_d = err_cnt_q + 8'd1;
                        end
                    end
`endif
                end
                ST_SSD1:          state_d = is_p3n ? ST_RECEIVE : ST_FALSE_CARRIER;
                ST_FALSE_CARRIER: if (is_data) state_d = ST_IDLE;
                ST_RECEIVE:       if (is_p4) state_d = ST_ESD1;
                ST_ESD1:          state_d = is_p3n ? ST_IDLE : ST_ESD_ERR;
                ST_ESD_ERR:       state_d = ST_IDLE;
                default:          state_d = ST_UNLOCKED;
            endcase
        end
    end

    // Output next values; rx_dv/rx_er/rxd hold when no beat is accepted.
    always_comb begin
        rxd_d      = rxd_q;
        rx_dv_d    = rx_dv_q;
        rx_er_d    = rx_er_q;
        rxerr_st_d = (state_d == ST_FALSE_CARRIER) || (state_d == ST_ESD_ERR);
        lock_d     = (state_d != ST_UNLOCKED) && (state_d != ST_VERIFY);
        if (!io_loc_rcvr_status) begin
            rx_dv_d = 1'b0;
            rx_er_d = 1'b0;
        end else if (accept) begin
            rx_dv_d = 1'b0;
            rx_er_d = 1'b0;
            case (state_q)
                ST_RECEIVE: begin
                    // A stray P3N inside a frame is passed up as a coding error.
                    if (!is_p4) begin
                        rx_dv_d = 1'b1;
                        rx_er_d = is_p3n;
                        rxd_d   = io_decoded_rx_symb_vector ^ scr_nxt[7:0];
                    end
                end
                ST_SSD1: begin
                    if (!is_p3n) begin
                        rx_er_d = 1'b1;
                        rxd_d   = FC_CODE;
                    end
                end
                ST_FALSE_CARRIER: begin
                    if (!is_data) begin
                        rx_er_d = 1'b1;
                        rxd_d   = FC_CODE;
                    end
                end
                ST_ESD1:  rx_er_d = ~is_p3n;
                default:  ;
            endcase
        end
    end

    assign io_rxd            = rxd_q;
    assign io_rx_dv          = rx_dv_q;
    assign io_rx_er          = rx_er_q;
    assign io_rxerror_status = rxerr_st_q;
    assign io_descr_lock     = lock_q;
`ifdef RX_IDLE_ERR_CNT_EN
    assign io_idle_err_cnt   = err_cnt_q;
`else
    assign io_idle_err_cnt   = '0;
`endif

endmodule

// File: tb/tb_pcs_rx_descrambler_sm.sv
// Bench for pcs_rx_descrambler_sm (MASTER=0, LOCK_MATCHES=16). A reference g_S LFSR
// supplies the idle stream and Scn; directed beats carry the outputs they must produce.
module tb_pcs_rx_descrambler_sm;

    localparam int unsigned LOCK_BEATS = 33 + 16;
    localparam logic [32:0] SEED = 33'h1_2345_6789;
    localparam logic [2:0]  P2 = 3'b010;
    localparam logic [2:0]  N2 = 3'b110;
    localparam logic [2:0]  P1 = 3'b001;
    localparam logic [2:0]  N1 = 3'b111;
    localparam logic [2:0]  Z0 = 3'b000;

    logic       clk = 1'b0;
    logic       rst_n, pcs_reset, loc_ok, valid, ready;
    logic [2:0] s0, s1, s2, s3;
    logic [7:0] dec, rxd, err_cnt;
    logic       rx_dv, rx_er, rxerr_st, lock;

    always #5 clk = ~clk;

    pcs_rx_descrambler_sm dut (
        .clock                    (clk),
        .reset                    (rst_n),
        .io_pcs_reset             (pcs_reset),
        .io_loc_rcvr_status       (loc_ok),
        .io_rx_symb_vector_valid  (valid),
        .io_rx_symb_vector_ready  (ready),
        .io_rx_symb_vector_bits_0 (s0),
        .io_rx_symb_vector_bits_1 (s1),
        .io_rx_symb_vector_bits_2 (s2),
        .io_rx_symb_vector_bits_3 (s3),
        .io_decoded_rx_symb_vector(dec),
        .io_rxd                   (rxd),
        .io_rx_dv                 (rx_dv),
        .io_rx_er                 (rx_er),
        .io_rxerror_status        (rxerr_st),
        .io_descr_lock            (lock),
        .io_idle_err_cnt          (err_cnt)
    );

    // Reference model state and current expectations.
    logic [32:0] lfsr;
    logic [7:0]  exp_rxd;
    logic        exp_dv, exp_er, exp_st, exp_lock, exp_ready;
    int          exp_cnt;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [32:0] lfsr_step(input logic [32:0] s);
        return {s[31:0], s[19] ^ s[32]};
    endfunction

    task automatic check(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Compare every cycle once out of reset.
    always @(negedge clk) begin
        if (chk_en) begin
            check("rxd", int'(rxd), int'(exp_rxd));
            check("rx_dv", int'(rx_dv), int'(exp_dv));
            check("rx_er", int'(rx_er), int'(exp_er));
            check("rxerror_status", int'(rxerr_st), int'(exp_st));
            check("descr_lock", int'(lock), int'(exp_lock));
            check("idle_err_cnt", int'(err_cnt), exp_cnt);
            check("ready", int'(ready), int'(exp_ready));
        end
    end

    // One accepted beat; payload is the plain byte, sent descrambled-domain as payload ^ Scn.
    task automatic beat(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c, input logic [2:0] d,
                        input logic [7:0] payload, input logic [7:0] e_rxd, input logic e_dv,
                        input logic e_er, input logic e_st, input logic e_lock, input int e_cnt);
        logic [32:0] nxt;
        nxt = lfsr_step(lfsr);
        s0 = a; s1 = b; s2 = c; s3 = d;
        dec = payload ^ nxt[7:0];
        valid = 1'b1;
        @(posedge clk); #1;
        valid    = 1'b0;
        lfsr     = nxt;
        exp_rxd  = e_rxd;
        exp_dv   = e_dv;
        exp_er   = e_er;
        exp_st   = e_st;
        exp_lock = e_lock;
        exp_cnt  = e_cnt;
    endtask

    task automatic idle_beat();
        beat(P1, Z0, N1, Z0, 8'h00, exp_rxd, 1'b0, 1'b0, 1'b0, 1'b1, 0);
    endtask

    task automatic gap();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pin;
        logic [32:0] s;
        int ucnt;
        rst_n = 1'b0; pcs_reset = 1'b0; loc_ok = 1'b1; valid = 1'b0;
        s0 = Z0; s1 = Z0; s2 = Z0; s3 = Z0; dec = 8'h00;
        lfsr = SEED;
        exp_rxd = 8'h00; exp_dv = 1'b0; exp_er = 1'b0; exp_st = 1'b0;
        exp_lock = 1'b0; exp_cnt = 0; exp_ready = 1'b0;

        // Pin the reference LFSR: first four g_S outputs from the seed are 1,1,0,0.
        s = SEED;
        for (int i = 0; i < 4; i++) begin
            s = lfsr_step(s);
            pin[i] = s[0];
        end
        check("lfsr_pin", int'(pin), 32'h3);

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", int'(ready), 0);
        check("rst_lock", int'(lock), 0);
        check("rst_dv", int'(rx_dv), 0);
        check("rst_rxd", int'(rxd), 0);
        rst_n = 1'b1;
        exp_ready = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;

        // Acquisition: lock rises on the accept edge of beat 49.
        for (int i = 1; i <= int'(LOCK_BEATS); i++)
            beat(P1, Z0, N1, Z0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, i >= int'(LOCK_BEATS), 0);
        idle_beat();

        // Good frame with a no-beat gap in the middle.
        beat(P2, P2, P2, P2, 8'h00, exp_rxd, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, N2, 8'h00, exp_rxd, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) begin
            beat(Z0, P1, N1, P1, 8'(i), 8'(i), 1'b1, 1'b0, 1'b0, 1'b1, 0);
            if (i == 1) gap();
        end
        beat(P2, P2, P2, P2, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, N2, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle_beat();

        // False carrier: P4 then a non-P3N beat; held through a P4 until the next idle beat.
        beat(P2, P2, P2, P2, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(Z0, Z0, Z0, Z0, 8'h00, 8'h0E, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        beat(P2, P2, P2, P2, 8'h00, 8'h0E, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        beat(P1, Z0, N1, Z0, 8'h00, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle_beat();

        // Bad ESD: one error beat, then back in IDLE (proved by a new frame starting).
        beat(P2, P2, P2, P2, 8'h00, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, N2, 8'h00, 8'h0E, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P1, P1, N1, N1, 8'h5A, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, P2, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, N2, P2, P2, 8'h00, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        beat(P1, Z0, N1, Z0, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, P2, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, N2, 8'h00, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(N2, P1, Z0, N1, 8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, P2, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, N2, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        idle_beat();

        // Receiver status drop mid-frame; a following P4/P3N must not open a frame.
        beat(P2, P2, P2, P2, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P2, P2, P2, N2, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        beat(P1, P1, P1, Z0, 8'h11, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 0);
        loc_ok = 1'b0;
        @(posedge clk); #1;
        loc_ok = 1'b1;
        exp_dv = 1'b0; exp_er = 1'b0; exp_lock = 1'b0; exp_st = 1'b0;
        ucnt = 0;
        beat(P2, P2, P2, P2, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 0); ucnt++;
        beat(P2, P2, P2, N2, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 0); ucnt++;
        beat(P1, P1, P1, Z0, 8'h22, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 0); ucnt++;
        // Relock from the retained state: 49 beats counted from the drop.
        while (ucnt < int'(LOCK_BEATS)) begin
            ucnt++;
            beat(P1, Z0, N1, Z0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, ucnt >= int'(LOCK_BEATS), 0);
        end
        idle_beat();

        // Eight idle beats with decoded[0] flipped.
        for (int k = 1; k <= 8; k++) begin
`ifdef RX_IDLE_ERR_CNT_EN
            beat(P1, Z0, N1, Z0, 8'h01, 8'h11, 1'b0, 1'b0, 1'b0, k < 8, (k < 8) ? k : 0);
`else
            beat(P1, Z0, N1, Z0, 8'h01, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 0);
`endif
        end

        // Synchronous clear colliding with a valid beat: clear wins.
        s0 = P2; s1 = P2; s2 = P2; s3 = P2; dec = 8'hFF;
        valid = 1'b1;
        pcs_reset = 1'b1;
        exp_ready = 1'b0;
        @(posedge clk); #1;
        exp_rxd = 8'h00; exp_dv = 1'b0; exp_er = 1'b0; exp_st = 1'b0;
        exp_lock = 1'b0; exp_cnt = 0;
        @(posedge clk); #1;
        valid = 1'b0;
        pcs_reset = 1'b0;
        exp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pcs_rx_descrambler_sm.md
Name: pcs_rx_descrambler_sm

Overview:
- Receive-side counterpart of the TX encoder/scrambler path in the 1000BASE-T PCS.
- Accepts one 4D symbol vector per symbol period, plus the byte recovered by the upstream trellis decoder.
- Acquires and locks a 33-bit descrambler from the idle stream, detects SSD/ESD framing, and descrambles data.
- Drives the GMII-style receive outputs (rxd, rx_dv, rx_er) toward the MAC.

Parameters:
- MASTER, 0, descrambler polynomial select. 1: g_M = 1+x^13+x^33. 0: g_S = 1+x^20+x^33.
- LOCK_MATCHES, 16, consecutive correct idle predictions required to declare lock (1..255).
- ERR_THRESH, 8, idle prediction errors that force unlock (used only with the optional feature).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- io_pcs_reset  in  1  synchronous clear, active-high; same effect as reset.
- io_loc_rcvr_status  in  1  1 = local receiver OK; 0 forces UNLOCKED.
- io_rx_symb_vector_valid  in  1  beat valid.
- io_rx_symb_vector_ready  out  1  beat accepted when valid && ready.
- io_rx_symb_vector_bits_0..3  in  3 each  PAM5 symbols A..D, two's complement, range -2..+2.
- io_decoded_rx_symb_vector  in  8  Sdn[7:0] for the same beat, from the trellis decoder.
- io_rxd  out  8  receive data.
- io_rx_dv  out  1  data valid.
- io_rx_er  out  1  receive error.
- io_rxerror_status  out  1  1 while any framing error state is active.
- io_descr_lock  out  1  descrambler locked.
- io_idle_err_cnt  out  8  saturating idle mismatch count.

Behaviour:
- Reset (async low or io_pcs_reset): Scr=0, state UNLOCKED, counters 0, all outputs 0. io_rx_symb_vector_ready=0 during reset and io_pcs_reset, otherwise 1.
- Outputs are registered and update on the clock edge that accepts a beat; latency is 1 cycle. With no beat accepted, rx_dv/rx_er hold their values.
- Beat classes:
  - P4 = (+2,+2,+2,+2).
  - P3N = (+2,+2,+2,-2).
  - Anything else is IDLE/DATA.
- Descrambler:
  - Scr[32:0] shifts left each accepted beat.
  - Scr_next[0] = Scr[12]^Scr[32] when MASTER=1, else Scr[19]^Scr[32].
  - Scn[7:0] = Scr[7:0], the same mapping as the TX scrambler.
- States:
  - UNLOCKED: each beat shifts decoded[0] into Scr[0] in place of the feedback bit. A 6-bit counter counts beats; at 33 go to VERIFY.
  - VERIFY: Scr runs free. A non-P4/P3N beat compares decoded[0] with predicted Scr_next[0]. A match increments the match counter; a mismatch clears both counters and returns to UNLOCKED. At LOCK_MATCHES go to IDLE and set io_descr_lock=1. P4/P3N beats in VERIFY clear the counters and return to UNLOCKED.
  - IDLE: P4 -> SSD1. Other beats -> stay IDLE.
  - SSD1: P3N -> RECEIVE, with no rx_dv on either SSD beat. Anything else -> FALSE_CARRIER.
  - FALSE_CARRIER: rx_er=1, rxd=0x0E, rx_dv=0. Leave to IDLE on the first non-P4/P3N beat.
  - RECEIVE: data beat -> rx_dv=1, rxd = decoded ^ Scn. P4 -> ESD1, with rx_dv=0 from that beat.
  - ESD1: P3N -> IDLE (good end). Otherwise ESD_ERR.
  - ESD_ERR: rx_er=1 for exactly one beat, then IDLE.
- io_rxerror_status=1 while in FALSE_CARRIER or ESD_ERR.
- io_loc_rcvr_status=0: at any state and any time (including mid-frame), go to UNLOCKED on the next edge. Clear rx_dv, rx_er and io_descr_lock, and clear the counters; Scr is retained.
- Scr advances on every accepted beat in every state except UNLOCKED.
- Simultaneous io_pcs_reset and a valid beat: reset wins and the beat is dropped.

Optional Feature:
- Macro RX_IDLE_ERR_CNT_EN.
- Defined: in IDLE, each data-class beat whose decoded[0] differs from Scr_next[0] increments io_idle_err_cnt, saturating at 255. Reaching ERR_THRESH forces UNLOCKED and clears the counter. The counter also clears on lock.
- Undefined: io_idle_err_cnt is tied to 0, no idle checking is done, and unlock occurs only via io_loc_rcvr_status or reset.

Test Plan:
- Reset/release, MASTER=0: feed 33+16 idle beats whose decoded[0] comes from a reference g_S LFSR seeded 0x1_2345_6789. io_descr_lock must rise on the accept edge of beat 49, with rx_dv=0 throughout.
- Locked, then P4, P3N, then 4 data beats carrying decoded = 0x00..0x03 ^ Scn, then P4, P3N. Required: rxd = 0x00, 0x01, 0x02, 0x03 with rx_dv=1 for exactly 4 cycles and rx_er=0.
- Locked, P4 followed by (0,0,0,0): rx_er=1 and rxd=0x0E until the next idle beat; io_rxerror_status=1 during that time.
- Mid-frame, P4 followed by (+2,-2,+2,+2): rx_er=1 for exactly one cycle, then the state returns to IDLE.
- Mid-frame, drop io_loc_rcvr_status: io_descr_lock=0 and rx_dv=0 on the next edge. A subsequent P4 must not start a frame.
- With RX_IDLE_ERR_CNT_EN and ERR_THRESH=8: inject 8 flipped idle bits. io_idle_err_cnt counts 1..7, then io_descr_lock=0 on the 8th.
